// File: rtl/iob_mem_boot_copy.sv
// Boot-copy engine: streams a ROM image into RAM after reset or on request,
// optionally reads it back to verify, then hands the RAM ports to the core.
module iob_mem_boot_copy #(
    parameter int DATA_W     = 32,
    parameter int ROM_ADDR_W = 10,
    parameter int RAM_ADDR_W = 13,
    parameter int N_WORDS    = 1024,
    parameter int DST_BASE   = 0,
    parameter int VERIFY     = 1,
    parameter int AUTO_START = 1
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_n_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  hold_o,
    output logic [DATA_W-1:0]     checksum_o,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0]     rom_r_data_i,
    input  logic                  core_r_en_i,
    input  logic [RAM_ADDR_W-1:0] core_r_addr_i,
    output logic [DATA_W-1:0]     core_r_data_o,
    input  logic [DATA_W/8-1:0]   core_w_strb_i,
    input  logic [RAM_ADDR_W-1:0] core_w_addr_i,
    input  logic [DATA_W-1:0]     core_w_data_i,
    output logic                  ram_r_en_o,
    output logic [RAM_ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0]     ram_r_data_i,
    output logic [DATA_W/8-1:0]   ram_w_strb_o,
    output logic [RAM_ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0]     ram_w_data_o
);

    localparam int CNT_W = $clog2(N_WORDS + 1);

    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(N_WORDS);
    localparam logic [RAM_ADDR_W-1:0] BASE     = RAM_ADDR_W'(DST_BASE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COPY   = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] ST_AFTER_COPY = (VERIFY != 0) ? ST_VERIFY : ST_DONE;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;      // issue-stage word index
    logic                  pend_q, pend_d;    // second stage holds a word
    logic [RAM_ADDR_W-1:0] waddr_q, waddr_d;  // RAM address of the pending word
    logic                  auto_q, auto_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     sum_q, sum_d;

    logic                  issue;
    logic [RAM_ADDR_W-1:0] issue_ram_addr;

    assign issue          = ((state_q == ST_COPY) || (state_q == ST_VERIFY)) && (cnt_q != LAST_CNT);
    assign issue_ram_addr = BASE + RAM_ADDR_W'(cnt_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        waddr_d = waddr_q;
        auto_d  = auto_q;
        err_d   = err_q;
        sum_d   = sum_q;

        // With cke_i low every register keeps its value, so the pipeline freezes intact.
        if (cke_i) begin
            pend_d  = issue;
            waddr_d = issue ? issue_ram_addr : '0;

            if (pend_q && (state_q == ST_COPY)) begin
                sum_d = sum_q + rom_r_data_i;
            end
            if (pend_q && (state_q == ST_VERIFY) && (rom_r_data_i != ram_r_data_i)) begin
                err_d = 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i || auto_q) begin
                        state_d = ST_COPY;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        sum_d   = '0;
                        auto_d  = 1'b0;
                    end
                end
                ST_COPY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_AFTER_COPY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            waddr_q <= '0;
            auto_q  <= (AUTO_START != 0);
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            waddr_q <= waddr_d;
            auto_q  <= auto_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

    assign busy_o     = (state_q == ST_COPY) || (state_q == ST_VERIFY);
    assign done_o     = (state_q == ST_DONE);
    assign hold_o     = (state_q != ST_DONE);
    assign err_o      = err_q;
    assign checksum_o = sum_q;

    // Memory ports: the engine owns them until DONE, then the core sees the RAM directly.
    always_comb begin
        rom_en_o      = 1'b0;
        rom_addr_o    = '0;
        ram_r_en_o    = 1'b0;
        ram_r_addr_o  = '0;
        ram_w_strb_o  = '0;
        ram_w_addr_o  = '0;
        ram_w_data_o  = '0;
        core_r_data_o = '0;

        case (state_q)
            ST_COPY: begin
                rom_en_o     = cke_i && issue;
                rom_addr_o   = issue ? ROM_ADDR_W'(cnt_q) : '0;
                ram_w_strb_o = (cke_i && pend_q) ? '1 : '0;
                ram_w_addr_o = waddr_q;
                ram_w_data_o = pend_q ? rom_r_data_i : '0;
            end
            ST_VERIFY: begin
                rom_en_o     = cke_i && issue;
                rom_addr_o   = issue ? ROM_ADDR_W'(cnt_q) : '0;
                ram_r_en_o   = cke_i && issue;
                ram_r_addr_o = issue ? issue_ram_addr : '0;
            end
            ST_DONE: begin
                ram_r_en_o    = core_r_en_i;
                ram_r_addr_o  = core_r_addr_i;
                ram_w_strb_o  = core_w_strb_i;
                ram_w_addr_o  = core_w_addr_i;
                ram_w_data_o  = core_w_data_i;
                core_r_data_o = ram_r_data_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_iob_mem_boot_copy.sv
// Bench for iob_mem_boot_copy: a small 16-word instance (no verify) and a
// full-depth instance (verify) against bench-side ROM/RAM and an image model.
module tb_iob_mem_boot_copy;

    localparam int NA = 16;
    localparam int BA = 256;
    localparam int NB = 1024;
    localparam int BB = 8192 - NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sent(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // ---------------- instance A: N=16, base 0x100, no verify
    logic        rst_a_n, cke_a, start_a;
    logic        busy_a, done_a, err_a, hold_a;
    logic [31:0] cks_a;
    logic        rom_en_a;
    logic [9:0]  rom_addr_a;
    logic [31:0] rom_rd_a;
    logic        core_r_en_a;
    logic [12:0] core_r_addr_a;
    logic [31:0] core_r_data_a;
    logic [3:0]  core_w_strb_a;
    logic [12:0] core_w_addr_a;
    logic [31:0] core_w_data_a;
    logic        ram_r_en_a;
    logic [12:0] ram_r_addr_a;
    logic [31:0] ram_rd_a;
    logic [3:0]  ram_w_strb_a;
    logic [12:0] ram_w_addr_a;
    logic [31:0] ram_w_data_a;

    iob_mem_boot_copy #(
        .DATA_W(32), .ROM_ADDR_W(10), .RAM_ADDR_W(13),
        .N_WORDS(NA), .DST_BASE(BA), .VERIFY(0), .AUTO_START(1)
    ) dut_a (
        .clk_i(clk), .cke_i(cke_a), .arst_n_i(rst_a_n), .start_i(start_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .hold_o(hold_a), .checksum_o(cks_a),
        .rom_en_o(rom_en_a), .rom_addr_o(rom_addr_a), .rom_r_data_i(rom_rd_a),
        .core_r_en_i(core_r_en_a), .core_r_addr_i(core_r_addr_a), .core_r_data_o(core_r_data_a),
        .core_w_strb_i(core_w_strb_a), .core_w_addr_i(core_w_addr_a), .core_w_data_i(core_w_data_a),
        .ram_r_en_o(ram_r_en_a), .ram_r_addr_o(ram_r_addr_a), .ram_r_data_i(ram_rd_a),
        .ram_w_strb_o(ram_w_strb_a), .ram_w_addr_o(ram_w_addr_a), .ram_w_data_o(ram_w_data_a)
    );

    // ---------------- instance B: full depth, top of RAM, verify
    logic        rst_b_n, cke_b, start_b;
    logic        busy_b, done_b, err_b, hold_b;
    logic [31:0] cks_b;
    logic        rom_en_b;
    logic [9:0]  rom_addr_b;
    logic [31:0] rom_rd_b;
    logic [31:0] core_r_data_b;
    logic        ram_r_en_b;
    logic [12:0] ram_r_addr_b;
    logic [31:0] ram_rd_b;
    logic [3:0]  ram_w_strb_b;
    logic [12:0] ram_w_addr_b;
    logic [31:0] ram_w_data_b;
    logic        core_idle_en;
    logic [12:0] core_idle_addr;
    logic [3:0]  core_idle_strb;
    logic [31:0] core_idle_data;

    iob_mem_boot_copy #(
        .DATA_W(32), .ROM_ADDR_W(10), .RAM_ADDR_W(13),
        .N_WORDS(NB), .DST_BASE(BB), .VERIFY(1), .AUTO_START(1)
    ) dut_b (
        .clk_i(clk), .cke_i(cke_b), .arst_n_i(rst_b_n), .start_i(start_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .hold_o(hold_b), .checksum_o(cks_b),
        .rom_en_o(rom_en_b), .rom_addr_o(rom_addr_b), .rom_r_data_i(rom_rd_b),
        .core_r_en_i(core_idle_en), .core_r_addr_i(core_idle_addr), .core_r_data_o(core_r_data_b),
        .core_w_strb_i(core_idle_strb), .core_w_addr_i(core_idle_addr), .core_w_data_i(core_idle_data),
        .ram_r_en_o(ram_r_en_b), .ram_r_addr_o(ram_r_addr_b), .ram_r_data_i(ram_rd_b),
        .ram_w_strb_o(ram_w_strb_b), .ram_w_addr_o(ram_w_addr_b), .ram_w_data_o(ram_w_data_b)
    );

    // ---------------- memory models (registered reads, byte-enable writes)
    logic [31:0] rom_a [1024];
    logic [31:0] ram_a [8192];
    logic [31:0] rom_b [1024];
    logic [31:0] ram_b [8192];
    logic        fill_a, fill_b, bd_en_b;
    logic [12:0] bd_addr_b;
    logic [31:0] bd_data_b;

    always @(posedge clk) begin
        if (rom_en_a) rom_rd_a <= rom_a[rom_addr_a];
        if (ram_r_en_a) ram_rd_a <= ram_a[ram_r_addr_a];
        if (fill_a) for (int k = 0; k < 8192; k++) ram_a[k] <= sent(k);
        for (int k = 0; k < 4; k++)
            if (ram_w_strb_a[k]) ram_a[ram_w_addr_a][8*k +: 8] <= ram_w_data_a[8*k +: 8];
    end

    always @(posedge clk) begin
        if (rom_en_b) rom_rd_b <= rom_b[rom_addr_b];
        if (ram_r_en_b) ram_rd_b <= ram_b[ram_r_addr_b];
        if (fill_b) for (int k = 0; k < 8192; k++) ram_b[k] <= sent(k);
        for (int k = 0; k < 4; k++)
            if (ram_w_strb_b[k]) ram_b[ram_w_addr_b][8*k +: 8] <= ram_w_data_b[8*k +: 8];
        if (bd_en_b) ram_b[bd_addr_b] <= bd_data_b;
    end

    // ---------------- engine write monitors
    logic [12:0] wq_a_addr[$];
    logic [31:0] wq_a_data[$];
    int          wstrb_bad_a = 0;
    int          nwr_b = 0;
    int          oor_b = 0;

    always @(posedge clk) begin
        if (busy_a && ram_w_strb_a != 4'h0) begin
            wq_a_addr.push_back(ram_w_addr_a);
            wq_a_data.push_back(ram_w_data_a);
            if (ram_w_strb_a != 4'hF) wstrb_bad_a++;
        end
        if (busy_b && ram_w_strb_b != 4'h0) begin
            nwr_b++;
            if (ram_w_addr_b < 13'(BB)) oor_b++;
        end
    end

    // ---------------- reference model helpers
    function automatic logic [31:0] sum_a();
        logic [31:0] s = 32'h0;
        for (int i = 0; i < NA; i++) s += rom_a[i];
        return s;
    endfunction

    function automatic logic [31:0] sum_b();
        logic [31:0] s = 32'h0;
        for (int i = 0; i < NB; i++) s += rom_b[i];
        return s;
    endfunction

    // Called at the start of cycle 1 of a copy (cycle k = period ending at enabled edge T+k).
    task automatic run_a(input int stall_at, input int stall_len, input int start_at,
                         input bit iso, output int lat);
        int k = 1;
        int first_rom = -1;
        int first_wr = -1;
        int bad_stall = 0;
        int bad_iso = 0;
        while (!done_a && k < 200) begin
            cke_a   = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            start_a = (k == start_at);
            core_w_strb_a = (iso && busy_a) ? 4'hF : 4'h0;
            core_w_addr_a = 13'(BA + 2);
            core_w_data_a = 32'hDEADBEEF;
            core_r_en_a   = iso && busy_a;
            core_r_addr_a = 13'(BA + 2);
            #1;
            if (first_rom < 0 && rom_en_a) first_rom = k;
            if (first_wr < 0 && ram_w_strb_a != 4'h0) first_wr = k;
            if (!cke_a && (rom_en_a || ram_r_en_a || ram_w_strb_a != 4'h0)) bad_stall++;
            if (iso && (core_r_data_a != 32'h0 || !hold_a || ram_r_en_a)) bad_iso++;
            @(negedge clk);
            k++;
        end
        cke_a = 1'b1;
        start_a = 1'b0;
        core_w_strb_a = 4'h0;
        core_r_en_a = 1'b0;
        lat = k;
        check("a_first_rom_cycle", 32'(first_rom), 32'd1);
        check("a_first_wr_cycle", 32'(first_wr), 32'd2);
        check("a_stall_enables", 32'(bad_stall), 32'd0);
        check("a_isolation", 32'(bad_iso), 32'd0);
    endtask

    task automatic check_image_a(input int base);
        int n = wq_a_addr.size() - base;
        int bad = 0;
        check("a_wr_count", 32'(n), 32'(NA));
        for (int i = 0; i < NA && i < n; i++)
            if (wq_a_addr[base+i] != 13'(BA + i) || wq_a_data[base+i] != rom_a[i]) bad++;
        check("a_wr_order", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < NA; i++) if (ram_a[BA+i] != rom_a[i]) bad++;
        check("a_ram_image", 32'(bad), 32'd0);
        check("a_below_base", ram_a[BA-1], sent(BA - 1));
        check("a_above_top", ram_a[BA+NA], sent(BA + NA));
        check("a_checksum", cks_a, sum_a());
        check("a_strb_all_ones", 32'(wstrb_bad_a), 32'd0);
        check("a_err_at_done", 32'(err_a), 32'd0);
    endtask

    task automatic run_b(input bit corrupt, output int lat, output int first_vrd);
        int k = 1;
        first_vrd = -1;
        while (!done_b && k < 2 * NB + 50) begin
            bd_en_b = 1'b0;
            if (first_vrd < 0 && ram_r_en_b) begin
                first_vrd = k;
                if (corrupt) begin
                    bd_en_b   = 1'b1;
                    bd_addr_b = 13'(BB + 5);
                    bd_data_b = ~rom_b[5];
                end
            end
            @(negedge clk);
            k++;
        end
        bd_en_b = 1'b0;
        lat = k;
    endtask

    task automatic check_image_b(input int wr_base);
        int bad = 0;
        for (int i = 0; i < NB; i++) if (ram_b[BB+i] != rom_b[i]) bad++;
        check("b_ram_image", 32'(bad), 32'd0);
        check("b_wr_count", 32'(nwr_b - wr_base), 32'(NB));
        check("b_no_wrap_writes", 32'(oor_b), 32'd0);
        check("b_top_word", ram_b[8191], rom_b[NB-1]);
        check("b_below_base", ram_b[BB-1], sent(BB - 1));
        check("b_ram_zero_untouched", ram_b[0], sent(0));
        check("b_checksum", cks_b, sum_b());
    endtask

    int lat, first_vrd, wbase, stall_at, start_at, found;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        cke_a = 1'b1;   cke_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        core_r_en_a = 1'b0; core_r_addr_a = '0;
        core_w_strb_a = 4'h0; core_w_addr_a = '0; core_w_data_a = '0;
        core_idle_en = 1'b0; core_idle_addr = '0; core_idle_strb = 4'h0; core_idle_data = '0;
        fill_a = 1'b1; fill_b = 1'b1;
        bd_en_b = 1'b0; bd_addr_b = '0; bd_data_b = '0;
        for (int i = 0; i < 1024; i++) begin
            rom_a[i] = (i < NA) ? 32'(i + 1) : $urandom;
            rom_b[i] = $urandom;
        end

        #2;
        check("a_rst_flags", 32'({busy_a, done_a, err_a, hold_a}), 32'b0001);
        check("a_rst_checksum", cks_a, 32'h0);
        check("a_rst_enables", 32'({rom_en_a, ram_r_en_a, ram_w_strb_a}), 32'h0);
        check("b_rst_flags", 32'({busy_b, done_b, err_b, hold_b}), 32'b0001);

        @(negedge clk);
        fill_a = 1'b0; fill_b = 1'b0;
        repeat (2) @(negedge clk);

        // Auto-start, ROM[i]=i+1: done in cycle 18, checksum 136
        wbase = wq_a_addr.size();
        rst_a_n = 1'b1;
        @(negedge clk);
        check("a_busy_cycle1", 32'({busy_a, hold_a, done_a}), 32'b110);
        run_a(0, 0, 0, 1'b0, lat);
        check("a_done_latency", 32'(lat), 32'(NA + 2));
        check_image_a(wbase);
        check("a_checksum_136", cks_a, 32'd136);

        // Restart from DONE with random image, 3-cycle stall, ignored start, core isolation
        for (int i = 0; i < NA; i++) rom_a[i] = $urandom;
        stall_at = $urandom_range(4, 10);
        start_at = $urandom_range(3, 14);
        wbase = wq_a_addr.size();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_restart_flags", 32'({busy_a, hold_a, done_a}), 32'b110);
        check("a_restart_cks_clear", cks_a, 32'h0);
        run_a(stall_at, 3, start_at, 1'b1, lat);
        check("a_stall_latency", 32'(lat), 32'(NA + 2 + 3));
        check_image_a(wbase);
        check("a_core_write_dropped", ram_a[BA+2], rom_a[2]);

        // Pass-through in DONE: the same core write now lands and reads back
        core_w_strb_a = 4'hF; core_w_addr_a = 13'(BA + 2); core_w_data_a = 32'hDEADBEEF;
        @(negedge clk);
        core_w_strb_a = 4'h0;
        core_r_en_a = 1'b1; core_r_addr_a = 13'(BA + 2);
        @(negedge clk);
        core_r_en_a = 1'b0;
        #1;
        check("a_core_readback", core_r_data_a, 32'hDEADBEEF);
        check("a_hold_released", 32'(hold_a), 32'd0);

        // Reset at word 7, then auto-start re-runs from word 0
        for (int i = 0; i < NA; i++) rom_a[i] = $urandom;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (rom_en_a && rom_addr_a == 10'd7) found = 1;
            else @(negedge clk);
        end
        check("a_word7_reached", 32'(found), 32'd1);
        rst_a_n = 1'b0;
        #1;
        check("a_async_rst_flags", 32'({busy_a, done_a, err_a, hold_a}), 32'b0001);
        check("a_async_rst_cks", cks_a, 32'h0);
        check("a_async_rst_enables", 32'({rom_en_a, ram_r_en_a, ram_w_strb_a}), 32'h0);
        check("a_async_rst_addrs", 32'({rom_addr_a, ram_w_addr_a}), 32'h0);
        check("a_async_rst_core_rd", core_r_data_a, 32'h0);
        repeat (2) @(negedge clk);
        wbase = wq_a_addr.size();
        rst_a_n = 1'b1;
        @(negedge clk);
        run_a(0, 0, 0, 1'b0, lat);
        check("a_rerun_latency", 32'(lat), 32'(NA + 2));
        check_image_a(wbase);

        // Full-depth instance with verify: clean pass
        wbase = nwr_b;
        rst_b_n = 1'b1;
        @(negedge clk);
        check("b_busy_cycle1", 32'({busy_b, hold_b}), 32'b11);
        run_b(1'b0, lat, first_vrd);
        check("b_done_latency", 32'(lat), 32'(2 * NB + 3));
        check("b_first_verify_read", 32'(first_vrd), 32'(NB + 2));
        check("b_err_clean", 32'(err_b), 32'd0);
        check_image_b(wbase);

        // Corrupt word 5 during verify: sticky error until the next start
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_restart_flags", 32'({busy_b, done_b, hold_b}), 32'b101);
        check("b_restart_cks_clear", cks_b, 32'h0);
        run_b(1'b1, lat, first_vrd);
        check("b_corrupt_latency", 32'(lat), 32'(2 * NB + 3));
        check("b_err_set", 32'(err_b), 32'd1);
        repeat (5) @(negedge clk);
        check("b_err_sticky", 32'({err_b, done_b}), 32'b11);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_err_cleared", 32'({err_b, done_b, busy_b}), 32'b001);
        run_b(1'b0, lat, first_vrd);
        check("b_err_clean_again", 32'({err_b, done_b}), 32'b01);
        check("b_core_rd_zero_busy", core_r_data_b, ram_rd_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/iob_mem_boot_copy.md
# iob_mem_boot_copy

Boot-copy engine between the SoC core's external-memory bus and a `iob_ram_t2p_be` instance. It is the parametrised successor to HEXFILE-preloaded external memory. After reset, or on request, it streams `N_WORDS` words from an `iob_rom_sp` image into RAM at a configurable base, then optionally reads the image back to verify it. It holds the core off the RAM until the copy completes, and afterwards passes the core's RAM ports through transparently.

## Interface
- `DATA_W`, 32: word width of the ROM, RAM and core data.
- `ROM_ADDR_W`, 10: ROM word-address width.
- `RAM_ADDR_W`, 13: RAM word-address width.
- `N_WORDS`, 1024: words copied. Range is 1..2^ROM_ADDR_W, and `DST_BASE + N_WORDS` must be ≤ 2^RAM_ADDR_W.
- `DST_BASE`, 0: RAM word address that receives ROM word 0.
- `VERIFY`, 1: when set, a read-back compare pass runs after the copy.
- `AUTO_START`, 1: when set, the copy starts on the first enabled edge after reset release.
- `clk_i` in 1: system clock.
- `cke_i` in 1: clock enable. When 0, all state is frozen.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: one-cycle pulse that (re)starts the copy.
- `busy_o` out 1: copy or verify is in progress.
- `done_o` out 1: image is resident and the core owns the RAM.
- `err_o` out 1: sticky verify mismatch.
- `hold_o` out 1: core hold request (OR it into the core reset).
- `checksum_o` out DATA_W: running sum of the copied words.
- `rom_en_o` out 1, `rom_addr_o` out ROM_ADDR_W, `rom_r_data_i` in DATA_W: ROM master. Read data is valid 1 cycle after `rom_en_o`.
- `core_r_en_i` in 1, `core_r_addr_i` in RAM_ADDR_W, `core_r_data_o` out DATA_W: core read port.
- `core_w_strb_i` in DATA_W/8, `core_w_addr_i` in RAM_ADDR_W, `core_w_data_i` in DATA_W: core write port.
- `ram_r_en_o` out 1, `ram_r_addr_o` out RAM_ADDR_W, `ram_r_data_i` in DATA_W: RAM read port. Read data is valid 1 cycle after `ram_r_en_o`.
- `ram_w_strb_o` out DATA_W/8, `ram_w_addr_o` out RAM_ADDR_W, `ram_w_data_o` out DATA_W: RAM write port.

## Operation
- **States:**
  - `IDLE`: reached from reset only when `AUTO_START`=0.
  - `COPY`: entered on the first enabled edge after reset release if `AUTO_START`=1.
  - `VERIFY`: entered after the copy when `VERIFY`=1.
  - `DONE`: entered after the copy when `VERIFY`=0, or after the verify pass.
  - Transitions: `COPY` → `VERIFY` if `VERIFY`=1, else → `DONE`. `VERIFY` → `DONE`. `IDLE`/`DONE` + `start_i` → `COPY`.
- **Start from `IDLE`/`DONE`:** `start_i` clears `done_o`, `err_o` and `checksum_o`, and asserts `hold_o`.
- **`start_i` while busy:** ignored in `COPY` and `VERIFY`.
- **`COPY` pipeline:** an issue counter `i` drives `rom_en_o`=1 and `rom_addr_o`=i, for i = 0..N_WORDS-1.
  - One enabled cycle later, the write stage drives `ram_w_addr_o`=DST_BASE+i, `ram_w_strb_o`=all ones and `ram_w_data_o`=`rom_r_data_i`.
  - In the same cycle, `checksum_o` += `rom_r_data_i` (mod 2^DATA_W).
  - Throughput is 1 word per enabled cycle.
- **`VERIFY`:** for each i, drive `rom_en_o`, `rom_addr_o`=i, `ram_r_en_o` and `ram_r_addr_o`=DST_BASE+i in the same cycle. One cycle later compare the two read words; any inequality sets `err_o`, which stays set until the next start.
- **Outside `DONE`:**
  - Core writes are dropped (`ram_w_strb_o` is driven by the engine only).
  - Core reads are ignored, and `core_r_data_o`=0.
  - `hold_o`=1.
- **In `DONE`:**
  - RAM ports equal the core ports combinationally, and `core_r_data_o`=`ram_r_data_i`.
  - `rom_en_o`=0 and `hold_o`=0.
- **`cke_i`=0:**
  - Counters, pipeline valid and state all hold.
  - `rom_en_o`, `ram_r_en_o` and engine `ram_w_strb_o` are forced 0, so the ROM/RAM output registers retain their data.
  - On resume, the pending write uses the held `rom_r_data_i`.
  - Core pass-through in `DONE` is unaffected.
- **Reset asserted mid-operation:** the copy is aborted immediately, all outputs return to their reset values, and `AUTO_START` re-runs the copy from word 0.

## Timing
- **Reset values:** `busy_o`=0, `done_o`=0, `err_o`=0, `hold_o`=1, `checksum_o`=0. All enables and strobes are 0, all addresses 0, and `core_r_data_o`=0.
- **Copy timeline:** with start at enabled edge T and `cke_i` continuously 1:
  - `busy_o`=1 from T+1.
  - ROM reads at cycles T+1..T+N.
  - RAM writes at cycles T+2..T+N+1.
- **`VERIFY`=0:** `done_o`=1 and `busy_o`=0 at T+N+2.
- **`VERIFY`=1:**
  - Verify reads at T+N+2..T+2N+1.
  - Compares at T+N+3..T+2N+2.
  - `done_o`=1 at T+2N+3.
- **Final values:** `checksum_o` is final no later than the cycle `done_o` rises, and `err_o` is valid in that same cycle.
- **Stalls:** each `cke_i`=0 cycle extends every later milestone by exactly 1 cycle.
- **N_WORDS=1:** the issue and write stages never overlap, and the timeline formulas still hold.

## Test plan
- **Auto-start, no verify:** `AUTO_START`=1, `VERIFY`=0, N_WORDS=16, DST_BASE=0x100, ROM[i]=i+1. Required: RAM[0x100..0x10F]=1..16, `checksum_o`=136, `done_o` rises exactly 18 cycles after the first enabled edge.
- **Verify pass and mismatch:** `VERIFY`=1, a clean image gives `err_o`=0 at done. Then force a RAM write corruption of word 5 during verify via a backdoor, and restart. Required: `err_o`=1, sticky until the next `start_i`, which clears it.
- **Stall:** during `COPY`, drop `cke_i` for 3 cycles mid-stream. Required: no duplicated or skipped word, RAM contents identical to the unstalled run, and `done_o` 3 cycles later.
- **Hold and isolation:** while `busy_o`=1, the core issues writes (strb 0xF, addr DST_BASE+2, data 0xDEADBEEF). Required: RAM is unchanged, `core_r_data_o`=0, `hold_o`=1. After done, the same core write lands and reads back 0xDEADBEEF.
- **Reset and restart:** assert `arst_n_i`=0 at word 7 of the copy. Required: all outputs at reset values asynchronously, and after release the copy restarts from word 0. `start_i` during `COPY` is ignored, while `start_i` in `DONE` re-copies and resets `checksum_o` first.
- **Full-depth boundary:** N_WORDS=2^ROM_ADDR_W and DST_BASE=2^RAM_ADDR_W − N_WORDS. Required: the last word lands at the top RAM address and no address wraps.
